// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: bundles the baud reference, request word/config and serial-line status of the frame builder.
// Latency: none, plain wires.
// Backpressure: busy from the slave gates acceptance of send from the master.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  baud_out;
    logic [DATA_WIDTH-1:0] data;
    logic                  send;
    logic [1:0]            parity_type;
    logic                  stop_bits;
    logic                  tx_out;
    logic                  busy;
    logic                  done;

    // Requester side: drives the word, its framing options and the baud wave
    modport master (
        output baud_out, data, send, parity_type, stop_bits,
        input  tx_out, busy, done
    );

    // Frame builder side
    modport slave (
        input  baud_out, data, send, parity_type, stop_bits,
        output tx_out, busy, done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one word as start bit, data LSB first, optional parity, then one or two stop bits.
// Latency: start bit begins on the first baud tick strictly after acceptance; each bit lasts one baud period.
// Backpressure: send is taken only while busy is low; requests during a frame are dropped, never queued.
// Build option: define UART_TX_PARITY_EN to build the parity bit; otherwise parity_type is ignored.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_tx_frame_if.slave bus
);
    localparam int            CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t                state_q;
    logic                  baud_q;
    logic                  tick;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  stop_cnt_q;   // 1 while a second stop bit is still owed
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_bit_q;    // parity bit computed from the word at acceptance
`else
    wire                   unused_parity_type = ^bus.parity_type;
`endif

    // One-cycle tick on each rising edge of the baud square wave
    assign tick = bus.baud_out & ~baud_q;

    // Previous baud level for the rising-edge detector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= bus.baud_out;
        end
    end

    // Frame FSM; line, busy and done are registered so every transition lands on a tick-closing edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (bus.send) begin
                        shift_q    <= bus.data;
                        stop_cnt_q <= bus.stop_bits;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_WAIT;
`ifdef UART_TX_PARITY_EN
                        // 01 odd, 10 even; 00 and 11 send no parity bit
                        par_en_q   <= bus.parity_type[0] ^ bus.parity_type[1];
                        par_bit_q  <= (^bus.data) ^ (bus.parity_type == 2'b01);
`endif
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (!stop_cnt_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table vectors, random frames against a bit-list model, and corner sequences.
// Latency: each bit is observed as 8 clock samples; BaudOut period is 8 clocks.
// Backpressure: exercises ignored sends while busy and back-to-back acceptance in the done cycle.
module tb_uart_tx_frame;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef bit bitq_t[$];
    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    pt;
        logic          sb;
        logic [11:0]   exp_frame;   // bit 0 goes on the line first
        int            exp_len;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();
    uart_tx_frame #(.DATA_WIDTH(DW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        bus.baud_out = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            bus.baud_out = ~bus.baud_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: list of line levels, one per bit period, from the framing rules
    function automatic bitq_t build_frame(input logic [DW-1:0] d, input logic [1:0] pt, input logic sb);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (PAR_EN && (pt == 2'b01 || pt == 2'b10)) begin
            if (pt == 2'b10) q.push_back(bit'(ones % 2));
            else             q.push_back(bit'(1 - (ones % 2)));
        end
        q.push_back(1'b1);
        if (sb) q.push_back(1'b1);
        return q;
    endfunction

    // Called at the first negedge after the acceptance edge; ends at the done sample
    task automatic check_frame(input string name, input bitq_t exp, input int exp_wait, input bit disturb);
        int   w = 0;
        bit   ok;
        logic got;
        while (bus.tx_out === 1'b1 && bus.busy === 1'b1 && bus.done === 1'b0 && w < 9) begin
            w++;
            @(negedge clk);
        end
        if (exp_wait == 0) check({name, " wait"}, (w >= 1 && w <= 8), w, 8);
        else               check({name, " wait"}, (w == exp_wait), w, exp_wait);
        foreach (exp[i]) begin
            ok  = 1'b1;
            got = exp[i];
            for (int c = 0; c < 8; c++) begin
                if (disturb && i == 3 && c == 0) begin
                    bus.send        = 1'b1;
                    bus.data        = ~bus.data;
                    bus.parity_type = ~bus.parity_type;
                    bus.stop_bits   = ~bus.stop_bits;
                end
                if (disturb && i == 5 && c == 0) bus.send = 1'b0;
                if (bus.tx_out !== exp[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    ok  = 1'b0;
                    got = bus.tx_out;
                end
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", name, i), ok, {31'd0, got}, {31'd0, exp[i]});
        end
        check({name, " done"}, (bus.done === 1'b1 && bus.busy === 1'b0 && bus.tx_out === 1'b1),
              {29'd0, bus.done, bus.busy, bus.tx_out}, 32'h5);
    endtask

    task automatic send_one(input string name, input logic [DW-1:0] d, input logic [1:0] pt, input logic sb,
                            input bitq_t exp, input bit hold, input bit disturb);
        bus.data        = d;
        bus.parity_type = pt;
        bus.stop_bits   = sb;
        bus.send        = 1'b1;
        @(negedge clk);
        if (!hold) bus.send = 1'b0;
        check_frame(name, exp, 0, disturb);
    endtask

    task automatic idle_after(input string name);
        @(negedge clk);
        check({name, " idle"}, (bus.done === 1'b0 && bus.busy === 1'b0 && bus.tx_out === 1'b1),
              {29'd0, bus.done, bus.busy, bus.tx_out}, 32'h1);
    endtask

    initial begin
        vec_t  vecs[6];
        bitq_t q;
        bit    ok;

        // Hand-derived expected frames, bit 0 first
        vecs[0] = '{8'hA5, 2'b00, 1'b0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[3] = '{8'h3C, 2'b11, 1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10};
        if (PAR_EN) begin
            vecs[1] = '{8'hA5, 2'b10, 1'b1, {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 12};
            vecs[2] = '{8'hA5, 2'b01, 1'b1, {1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}, 12};
            vecs[4] = '{8'hFF, 2'b01, 1'b0, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11};
            vecs[5] = '{8'h00, 2'b10, 1'b1, {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}, 12};
        end else begin
            vecs[1] = '{8'hA5, 2'b10, 1'b1, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
            vecs[2] = '{8'hA5, 2'b01, 1'b1, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
            vecs[4] = '{8'hFF, 2'b01, 1'b0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};
            vecs[5] = '{8'h00, 2'b10, 1'b1, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11};
        end

        bus.data        = '0;
        bus.send        = 1'b0;
        bus.parity_type = 2'b00;
        bus.stop_bits   = 1'b0;

        // Reset state, then 100 idle clocks
        repeat (3) @(negedge clk);
        check("reset state", (bus.tx_out === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0),
              {29'd0, bus.tx_out, bus.busy, bus.done}, 32'h4);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
        end
        check("idle 100", ok, {29'd0, bus.tx_out, bus.busy, bus.done}, 32'h4);

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].exp_len; i++) q.push_back(vecs[v].exp_frame[i]);
            send_one($sformatf("vec%0d", v), vecs[v].data, vecs[v].pt, vecs[v].sb, q, 1'b0, 1'b0);
            idle_after($sformatf("vec%0d", v));
        end

        // Send held high: each next frame accepted in the done cycle, one idle bit between frames
        q = build_frame(8'h3C, 2'b00, 1'b0);
        send_one("b2b0", 8'h3C, 2'b00, 1'b0, q, 1'b1, 1'b0);
        for (int f = 1; f < 3; f++) begin
            if (f == 2) begin
                @(negedge clk);
                bus.send = 1'b0;
                check_frame("b2b2", q, 7, 1'b0);
            end else begin
                @(negedge clk);
                check_frame("b2b1", q, 7, 1'b0);
            end
        end
        idle_after("b2b");

        // Send and new inputs mid-frame are ignored, no queued frame afterwards
        q = build_frame(8'h5A, 2'b10, 1'b0);
        send_one("busy_send", 8'h5A, 2'b10, 1'b0, q, 1'b0, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
        end
        check("no queued frame", ok, {29'd0, bus.done, bus.busy, bus.tx_out}, 32'h1);

        // Reset during the data bits
        bus.data = 8'hC3; bus.parity_type = 2'b00; bus.stop_bits = 1'b0; bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (8 + 8 + 24) @(negedge clk);
        check("busy before reset", (bus.busy === 1'b1), {31'd0, bus.busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("async reset", (bus.tx_out === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0),
                 {29'd0, bus.tx_out, bus.busy, bus.done}, 32'h4);
        ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx_out !== 1'b1) ok = 1'b0;
        end
        check("no done after reset", ok, {29'd0, bus.done, bus.busy, bus.tx_out}, 32'h1);
        q = build_frame(8'h96, 2'b01, 1'b1);
        send_one("post_reset", 8'h96, 2'b01, 1'b1, q, 1'b0, 1'b0);
        idle_after("post_reset");

        // Random frames with random gaps against the model
        for (int r = 0; r < 8; r++) begin
            logic [DW-1:0] d;
            logic [1:0]    pt;
            logic          sb;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            d  = DW'($urandom);
            pt = 2'($urandom_range(0, 3));
            sb = 1'($urandom_range(0, 1));
            q  = build_frame(d, pt, sb);
            send_one($sformatf("rnd%0d", r), d, pt, sb, q, 1'b0, 1'b0);
            idle_after($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
